// File: rtl/mod_n_counter_fsm.sv
// mod_n_counter_fsm: modulo-N up/down counter as a registered Moore FSM with
// load, hold, wrap-around or one-shot stop at terminal count.
module mod_n_counter_fsm #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5,
    parameter int INIT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             done
);
    typedef enum logic {RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] START = WIDTH'(INIT);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;
    assign tc   = up_dn ? (out == LAST) : (out == '0);
    assign done = (state == DONE);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            out   <= START;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            wrap  <= wrap_nxt;
        end
    end
    // Wrap targets are explicit so MODULUS < 2**WIDTH never relies on rollover.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        wrap_nxt  = 1'b0;
        if (load) begin
            state_nxt = RUN;
            out_nxt   = (load_val > LAST) ? LAST : load_val;
        end else if (state == RUN && en) begin
            if (!tc)
                out_nxt = up_dn ? out + 1'b1 : out - 1'b1;
            else if (one_shot)
                state_nxt = DONE;
            else begin
                out_nxt  = up_dn ? '0 : LAST;
                wrap_nxt = 1'b1;
            end
        end
    end
endmodule
